// File: rtl/sram_sync_ctrl_if.sv
// sram_sync_ctrl_if: request/response bundle between a bus master
// and the synchronous SRAM controller.
interface sram_sync_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              chip_select;
  logic              read_write_select;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic              clear_req;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              parity_err;

  modport master (
    output chip_select, read_write_select, address, wdata, clear_req,
    input  ready, rdata, rdata_valid, parity_err
  );

  modport slave (
    input  chip_select, read_write_select, address, wdata, clear_req,
    output ready, rdata, rdata_valid, parity_err
  );
endinterface

// File: rtl/sram_sync_ctrl.sv
// sram_sync_ctrl: single-port synchronous SRAM, registered read, clear sweep.
// Define SRAM_PARITY_EN to store an even-parity bit per word.
module sram_sync_ctrl #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  sram_sync_ctrl_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = ADDR_W + 1;
`ifdef SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);

  logic [MEM_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              perr_q, perr_d;

  logic              acc_rd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] wd;
  logic [MEM_W-1:0]  mem_wword;
  logic [MEM_W-1:0]  rd_word;

  assign rd_word = mem_q[bus.address];

`ifdef SRAM_PARITY_EN
  assign mem_wword = {^wd, wd};
`else
  assign mem_wword = wd;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.address;
    wd        = bus.wdata;
    unique case (1'b1)
      (state_q == ST_CLEAR): begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_W-1:0];
        wd        = '0;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      (state_q == ST_IDLE): begin
        // a clear request pre-empts any access presented on the same edge
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (bus.chip_select) begin
          if (bus.read_write_select) mem_we = 1'b1;
          else                       acc_rd = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready_d  = (state_d == ST_IDLE);
    rvalid_d = acc_rd;
    rdata_d  = acc_rd ? rd_word[DATA_W-1:0] : rdata_q;
`ifdef SRAM_PARITY_EN
    perr_d   = acc_rd && (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
`else
    perr_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wword;
  end

  assign bus.ready       = ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.parity_err  = perr_q;

endmodule

// File: tb/tb_sram_sync_ctrl.sv
// tb_sram_sync_ctrl: scoreboard bench for sram_sync_ctrl.
// Reads push expected words at accept; the monitor pops on rdata_valid.
module tb_sram_sync_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          pe;
  } exp_t;

  logic clk;
  logic rst_n;

  sram_sync_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sram_sync_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  exp_t q[$];
  logic [DW-1:0] model [16];
  int run_len = 0;
  int max_run = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rdata_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (q.size() == 0) begin
        chk("spurious_rv", 32'(bus.rdata_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rdata", 32'(bus.rdata), 32'(e.d));
        chk("perr", 32'(bus.parity_err), 32'(e.pe));
      end
    end else begin
      run_len = 0;
      if (rst_n) chk("perr_idle", 32'(bus.parity_err), 32'd0);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  task automatic access(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit push);
    int w;
    w = 0;
    bus.chip_select       = 1'b1;
    bus.read_write_select = wr;
    bus.address           = a;
    bus.wdata             = d;
    while (!bus.ready && w < 100) begin
      cyc(1);
      w++;
    end
    if (!bus.ready) begin
      chk("access_timeout", 32'd0, 32'd1);
    end else begin
      cyc(1);
      if (wr) model[a] = d;
      else if (push) q.push_back('{model[a], 1'b0});
    end
    bus.chip_select = 1'b0;
  endtask

  task automatic sweep(input string tag, input int pulse_at);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      bus.clear_req = (n == pulse_at);
      cyc(1);
      n++;
    end
    bus.clear_req = 1'b0;
    chk(tag, 32'(n), 32'd16);
    clr_model();
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while (q.size() != 0 && w < 20) begin
      cyc(1);
      w++;
    end
    chk(tag, 32'(q.size()), 32'd0);
    cyc(1);
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.chip_select       = 1'b0;
    bus.read_write_select = 1'b0;
    bus.address           = '0;
    bus.wdata             = '0;
    bus.clear_req         = 1'b0;
    clr_model();

    #3;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_rv", 32'(bus.rdata_valid), 32'd0);
    chk("rst_perr", 32'(bus.parity_err), 32'd0);
    cyc(2);
    rst_n = 1'b1;

    // 1: initial sweep, then every word reads zero
    sweep("t1_sweep", -1);
    for (int i = 0; i < 16; i++) access(1'b0, AW'(i), '0, 1'b1);
    drain("t1_drain");

    // 2: read right behind a write to the same word
    access(1'b1, 4'd3, 8'hA5, 1'b0);
    access(1'b0, 4'd3, '0, 1'b1);
    chk("t2_rv_now", 32'(bus.rdata_valid), 32'd1);
    chk("t2_rdata", 32'(bus.rdata), 32'hA5);
    cyc(1);
    chk("t2_rv_drop", 32'(bus.rdata_valid), 32'd0);
    chk("t2_rdata_hold", 32'(bus.rdata), 32'hA5);
    drain("t2_drain");

    // 3: streamed writes then back-to-back reads
    for (int i = 0; i < 16; i++)
      access(1'b1, AW'(i), DW'(i) ^ 8'h5A, 1'b0);
    max_run = 0;
    for (int i = 0; i < 16; i++) access(1'b0, AW'(i), '0, 1'b1);
    drain("t3_drain");
    chk("t3_run", 32'(max_run), 32'd16);

    // 4: clear pre-empts a simultaneous write; mid-sweep request ignored
    access(1'b1, 4'd7, 8'hFF, 1'b0);
    bus.clear_req         = 1'b1;
    bus.chip_select       = 1'b1;
    bus.read_write_select = 1'b1;
    bus.address           = 4'd8;
    bus.wdata             = 8'h11;
    cyc(1);
    bus.clear_req   = 1'b0;
    bus.chip_select = 1'b0;
    sweep("t4_sweep", 8);
    access(1'b0, 4'd7, '0, 1'b1);
    access(1'b0, 4'd8, '0, 1'b1);
    drain("t4_drain");

    // 5: reset mid-sweep and right after a read accept
    bus.clear_req = 1'b1;
    cyc(1);
    bus.clear_req = 1'b0;
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(bus.ready), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    sweep("t5_sweep_a", -1);
    access(1'b1, 4'd5, 8'h77, 1'b0);
    access(1'b0, 4'd5, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rv", 32'(bus.rdata_valid), 32'd0);
    chk("t5_rst_rdata", 32'(bus.rdata), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    sweep("t5_sweep_b", -1);
    access(1'b0, 4'd5, '0, 1'b1);
    drain("t5_drain");

    // 6: parity error detection on a corrupted word
    access(1'b1, 4'd2, 8'h3C, 1'b0);
`ifdef SRAM_PARITY_EN
    dut.mem_q[2][0] = ~dut.mem_q[2][0];
    access(1'b0, 4'd2, '0, 1'b0);
    q.push_back('{8'h3D, 1'b1});
`else
    access(1'b0, 4'd2, '0, 1'b1);
`endif
    drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
